ex_forward_source: RTL and testbench
====================================

// Module: ex_forward_source
// PURPOSE
//   Producer side of the EX-stage forwarding interface. It holds the EX/MEM and
//   MEM/WB pipeline registers and drives preData, prePreData, forwardA and
//   forwardB back to the EX stage. It also raises a one-cycle load-use stall
//   and supplies the write-back port of the register file.
// PARAMETERS
//   DW   32  datapath width (preData, prePreData, wb_data)
//   RW    5  register-specifier width
//   CW   16  statistics counter width (FWD_STATS_EN only)
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   flush         in   1   squash the instruction entering EX/MEM (branch taken)
//   ex_RegWrite   in   1   EX instruction writes a register
//   ex_MemRead    in   1   EX instruction is a load
//   ex_ALUOut     in   DW  ALU result of the EX instruction
//   ex_RegDest    in   RW  destination register of the EX instruction
//   ex_Rs, ex_Rt  in   RW  source registers of the EX instruction
//   mem_rdata     in   DW  data-memory read data for the EX/MEM instruction
//   preData       out  DW  EX/MEM ALU result (forwardX = 2'b01)
//   prePreData    out  DW  MEM/WB write-back value (forwardX = 2'b10)
//   forwardA      out  2   Rs source select: 00 regfile, 01 preData, 10 prePreData
//   forwardB      out  2   Rt source select, same encoding as forwardA
//   stall_req     out  1   load-use hazard: hold PC, IF/ID and ID/EX
//   wb_RegWrite   out  1   register-file write enable
//   wb_RegDest    out  RW  register-file write address
//   wb_data       out  DW  register-file write data (same as prePreData)
//   fwd_count     out  CW  count of forwarded operands (FWD_STATS_EN)
//   stall_count   out  CW  count of stall cycles (FWD_STATS_EN)
// BEHAVIOUR
// - Reset clears all EX/MEM and MEM/WB fields to 0. Immediately after reset:
//   all outputs are 0, forwardA = forwardB = 00 and stall_req = 0.
// - EX/MEM register (xm_*): RegWrite, MemRead, RegDest, ALUOut. It loads the
//   ex_* inputs every clock. It loads a bubble (RegWrite = 0, MemRead = 0, other
//   fields are don't-care) when flush = 1 or stall_req = 1.
// - MEM/WB register (mw_*): RegWrite, RegDest, Data. It loads from EX/MEM every
//   clock. Data = xm_MemRead ? mem_rdata : xm_ALUOut. MEM/WB is never stalled.
// - preData = xm_ALUOut. prePreData = wb_data = mw_Data.
//   wb_RegWrite = mw_RegWrite. wb_RegDest = mw_RegDest.
// - forwardA is combinational from registered state and ex_Rs:
//     01 when xm_RegWrite && !xm_MemRead && xm_RegDest == ex_Rs && ex_Rs != 0
//     else 10 when mw_RegWrite && mw_RegDest == ex_Rs && ex_Rs != 0
//     else 00.
//   EX/MEM has priority over MEM/WB (younger value wins). forwardB is the same
//   using ex_Rt. Register 0 is never forwarded.
// - stall_req = xm_MemRead && xm_RegWrite && xm_RegDest != 0 &&
//   (xm_RegDest == ex_Rs || xm_RegDest == ex_Rt).
//   - While stall_req is high, the upstream stages hold, so ex_* stays stable.
//   - Next cycle the load is in MEM/WB, so forwarding uses 10 and stall_req
//     drops. A stall lasts exactly one cycle.
// - Latency: the EX result is in preData 1 cycle later and in prePreData 2
//   cycles later.
// - flush and stall_req together: one bubble enters EX/MEM (behaviour is
//   identical).
// - Reset mid-operation: state clears asynchronously, and pending forwards and
//   stalls are abandoned.
// CONFIGURATION
// - FWD_STATS_EN defined:
//   - fwd_count increments by (forwardA != 00) + (forwardB != 00) each cycle
//     stall_req = 0.
//   - stall_count increments by 1 each cycle stall_req = 1.
//   - Both counters saturate at 2^CW-1 and reset to 0.
// - FWD_STATS_EN undefined: no counter flops are built, and fwd_count and
//   stall_count are tied to 0.
// TESTING
// - add r3 in EX, then next-cycle use of r3 as Rs -> forwardA = 01,
//   preData = ALU result, stall_req = 0.
// - Producer r5, one independent instruction, then consumer of r5 as Rt ->
//   forwardB = 10, prePreData = producer value.
// - r4 written by both EX/MEM (0x11) and MEM/WB (0x22), consumer Rs = r4 ->
//   forwardA = 01, preData = 0x11.
// - lw r7 followed by a use of r7 -> stall_req = 1 for exactly 1 cycle, bubble
//   in EX/MEM, then forwardA = 10 with prePreData = mem_rdata.
// - Writes to r0, and flush = 1 on a writer -> forwardA = forwardB = 00, and
//   the bubble gives wb_RegWrite = 0 two cycles later.
// - rst asserted mid-stream -> all outputs 0 asynchronously. With FWD_STATS_EN,
//   run 3 forwards and 1 stall -> fwd_count = 3, stall_count = 1.

Source files
------------

// File: rtl/ex_forward_source.sv
// EX/MEM and MEM/WB pipeline registers with forwarding selects, load-use stall and write-back port.
// Optional FWD_STATS_EN builds saturating forward/stall counters; otherwise they are tied to 0.
module ex_forward_source #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ex_RegWrite,
  input  logic          ex_MemRead,
  input  logic [DW-1:0] ex_ALUOut,
  input  logic [RW-1:0] ex_RegDest,
  input  logic [RW-1:0] ex_Rs,
  input  logic [RW-1:0] ex_Rt,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] preData,
  output logic [DW-1:0] prePreData,
  output logic [1:0]    forwardA,
  output logic [1:0]    forwardB,
  output logic          stall_req,
  output logic          wb_RegWrite,
  output logic [RW-1:0] wb_RegDest,
  output logic [DW-1:0] wb_data,
  output logic [CW-1:0] fwd_count,
  output logic [CW-1:0] stall_count
);

  logic          r_xmRegWrite;
  logic          r_xmMemRead;
  logic [RW-1:0] r_xmRegDest;
  logic [DW-1:0] r_xmALUOut;
  logic          r_mwRegWrite;
  logic [RW-1:0] r_mwRegDest;
  logic [DW-1:0] r_mwData;

  logic [1:0]    w_fwdA;
  logic [1:0]    w_fwdB;
  logic          w_stall;
  logic          w_bubble;

  // A load in EX/MEM cannot forward yet; its data only exists once it reaches MEM/WB.
  always_comb begin
    w_fwdA = 2'b00;
    if (ex_Rs != '0) begin
      if (r_xmRegWrite && !r_xmMemRead && r_xmRegDest == ex_Rs)
        w_fwdA = 2'b01;
      else if (r_mwRegWrite && r_mwRegDest == ex_Rs)
        w_fwdA = 2'b10;
    end
  end

  always_comb begin
    w_fwdB = 2'b00;
    if (ex_Rt != '0) begin
      if (r_xmRegWrite && !r_xmMemRead && r_xmRegDest == ex_Rt)
        w_fwdB = 2'b01;
      else if (r_mwRegWrite && r_mwRegDest == ex_Rt)
        w_fwdB = 2'b10;
    end
  end

  assign w_stall  = r_xmMemRead && r_xmRegWrite && (r_xmRegDest != '0) &&
                    ((r_xmRegDest == ex_Rs) || (r_xmRegDest == ex_Rt));
  assign w_bubble = flush || w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xmRegWrite <= 1'b0;
      r_xmMemRead  <= 1'b0;
      r_xmRegDest  <= '0;
      r_xmALUOut   <= '0;
      r_mwRegWrite <= 1'b0;
      r_mwRegDest  <= '0;
      r_mwData     <= '0;
    end else begin
      r_xmRegWrite <= ex_RegWrite && !w_bubble;
      r_xmMemRead  <= ex_MemRead && !w_bubble;
      r_xmRegDest  <= ex_RegDest;
      r_xmALUOut   <= ex_ALUOut;
      r_mwRegWrite <= r_xmRegWrite;
      r_mwRegDest  <= r_xmRegDest;
      r_mwData     <= r_xmMemRead ? mem_rdata : r_xmALUOut;
    end
  end

  assign preData     = r_xmALUOut;
  assign prePreData  = r_mwData;
  assign wb_data     = r_mwData;
  assign wb_RegWrite = r_mwRegWrite;
  assign wb_RegDest  = r_mwRegDest;
  assign forwardA    = w_fwdA;
  assign forwardB    = w_fwdB;
  assign stall_req   = w_stall;

`ifdef FWD_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] r_fwdCount;
  logic [CW-1:0] r_stallCount;
  logic [1:0]    w_fwdInc;
  logic [CW:0]   w_fwdSum;

  assign w_fwdInc = {1'b0, (w_fwdA != 2'b00)} + {1'b0, (w_fwdB != 2'b00)};
  assign w_fwdSum = {1'b0, r_fwdCount} + {{(CW-1){1'b0}}, w_fwdInc};

  // Forwards are only counted on cycles that actually issue, i.e. not while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwdCount   <= '0;
      r_stallCount <= '0;
    end else if (w_stall) begin
      if (r_stallCount != CNT_MAX)
        r_stallCount <= r_stallCount + 1'b1;
    end else begin
      r_fwdCount <= (w_fwdSum > {1'b0, CNT_MAX}) ? CNT_MAX : w_fwdSum[CW-1:0];
    end
  end

  assign fwd_count   = r_fwdCount;
  assign stall_count = r_stallCount;
`else
  assign fwd_count   = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_forward_source.sv
// Testbench for ex_forward_source: directed scenarios plus randomized traffic checked
// against an instruction-history model of the forwarding rules.
module tb_ex_forward_source;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          ex_RegWrite = 1'b0;
  logic          ex_MemRead = 1'b0;
  logic [DW-1:0] ex_ALUOut = '0;
  logic [RW-1:0] ex_RegDest = '0;
  logic [RW-1:0] ex_Rs = '0;
  logic [RW-1:0] ex_Rt = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] preData, prePreData, wb_data;
  logic [1:0]    forwardA, forwardB;
  logic          stall_req, wb_RegWrite;
  logic [RW-1:0] wb_RegDest;
  logic [CW-1:0] fwd_count, stall_count;

  int total = 0;
  int bad = 0;

  ex_forward_source #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_ALUOut(ex_ALUOut),
    .ex_RegDest(ex_RegDest), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .mem_rdata(mem_rdata),
    .preData(preData), .prePreData(prePreData), .forwardA(forwardA), .forwardB(forwardB),
    .stall_req(stall_req), .wb_RegWrite(wb_RegWrite), .wb_RegDest(wb_RegDest),
    .wb_data(wb_data), .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // One issued instruction slot; known = 0 marks a bubble whose data fields are don't-care.
  typedef struct {
    logic        wr;
    logic        ld;
    logic        known;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] value;
  } instT;

  instT hist[$];
  logic [1:0]  expFwdA, expFwdB;
  logic        expStall, expPreKnown, expWbKnown, expWbWr;
  logic [31:0] expPre, expPP;
  logic [4:0]  expWbDest;
  int          cntF, cntS;

  function automatic logic [1:0] fwdSel(input instT young, input instT old, input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (young.wr && !young.ld && young.dest == r) return 2'b01;
    if (old.wr && old.dest == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic modelReset();
    instT z;
    z = '{wr: 1'b0, ld: 1'b0, known: 1'b1, dest: 5'd0, alu: 32'd0, value: 32'd0};
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    cntF = 0;
    cntS = 0;
  endtask

  // Drive one instruction into EX and derive what the outputs must show this cycle.
  task automatic applyStimulus(input logic wr, input logic ld, input logic [31:0] alu,
                               input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                               input logic fl, input logic [31:0] rdata);
    instT e1, e2;
    @(negedge clk);
    ex_RegWrite = wr; ex_MemRead = ld; ex_ALUOut = alu; ex_RegDest = dest;
    ex_Rs = rs; ex_Rt = rt; flush = fl; mem_rdata = rdata;
    e1 = hist[hist.size()-1];
    e2 = hist[hist.size()-2];
    e1.value = e1.ld ? rdata : e1.alu;
    hist[hist.size()-1] = e1;
    expFwdA     = fwdSel(e1, e2, rs);
    expFwdB     = fwdSel(e1, e2, rt);
    expStall    = e1.wr && e1.ld && e1.dest != 5'd0 && (e1.dest == rs || e1.dest == rt);
    expPre      = e1.alu;
    expPreKnown = e1.known;
    expPP       = e2.value;
    expWbWr     = e2.wr;
    expWbDest   = e2.dest;
    expWbKnown  = e2.known;
    #1;
  endtask

  task automatic commit();
    instT n;
    int inc;
    @(posedge clk);
    if (expStall) begin
      if (cntS < CNT_MAX) cntS++;
    end else begin
      inc = (expFwdA != 2'b00 ? 1 : 0) + (expFwdB != 2'b00 ? 1 : 0);
      cntF = (cntF + inc > CNT_MAX) ? CNT_MAX : cntF + inc;
    end
    n.known = !(flush || expStall);
    n.wr    = ex_RegWrite && n.known;
    n.ld    = ex_MemRead && n.known;
    n.dest  = ex_RegDest;
    n.alu   = ex_ALUOut;
    n.value = ex_ALUOut;
    hist.push_back(n);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic test_reset();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (preData !== 32'd0) begin bad++; $display("[TB] FAIL reset_preData got=%h want=0", preData); end
    total++; if (prePreData !== 32'd0) begin bad++; $display("[TB] FAIL reset_prePreData got=%h want=0", prePreData); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_wb_data got=%h want=0", wb_data); end
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL reset_forwardA got=%b want=00", forwardA); end
    total++; if (forwardB !== 2'b00) begin bad++; $display("[TB] FAIL reset_forwardB got=%b want=00", forwardB); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stall_req); end
    total++; if (wb_RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb_RegWrite got=%b want=0", wb_RegWrite); end
    total++; if (wb_RegDest !== 5'd0) begin bad++; $display("[TB] FAIL reset_wb_RegDest got=%0d want=0", wb_RegDest); end
    total++; if (fwd_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_fwd_count got=%0d want=0", fwd_count); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_stall_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_forward_ex();
    applyStimulus(1, 0, 32'h1234, 3, 1, 2, 0, 0); commit();
    applyStimulus(1, 0, 32'h55, 6, 3, 0, 0, 0);
    total++; if (forwardA !== 2'b01) begin bad++; $display("[TB] FAIL ex_forwardA got=%b want=01", forwardA); end
    total++; if (preData !== 32'h1234) begin bad++; $display("[TB] FAIL ex_preData got=%h want=1234", preData); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("[TB] FAIL ex_stall got=%b want=0", stall_req); end
    commit();
  endtask

  task automatic test_forward_mem();
    applyStimulus(1, 0, 32'hA5A5, 5, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h1, 9, 0, 0, 0, 0); commit();
    applyStimulus(0, 0, 32'h0, 0, 1, 5, 0, 0);
    total++; if (forwardB !== 2'b10) begin bad++; $display("[TB] FAIL mem_forwardB got=%b want=10", forwardB); end
    total++; if (prePreData !== 32'hA5A5) begin bad++; $display("[TB] FAIL mem_prePreData got=%h want=a5a5", prePreData); end
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL mem_forwardA got=%b want=00", forwardA); end
    commit();
  endtask

  task automatic test_priority();
    applyStimulus(1, 0, 32'h22, 4, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h11, 4, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h33, 12, 4, 0, 0, 0);
    total++; if (forwardA !== 2'b01) begin bad++; $display("[TB] FAIL prio_forwardA got=%b want=01", forwardA); end
    total++; if (preData !== 32'h11) begin bad++; $display("[TB] FAIL prio_preData got=%h want=11", preData); end
    commit();
  endtask

  task automatic test_load_use();
    applyStimulus(1, 1, 32'h100, 7, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h77, 8, 7, 0, 0, 32'hDEADBEEF);
    total++; if (stall_req !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall_on got=%b want=1", stall_req); end
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL lu_forwardA_stall got=%b want=00", forwardA); end
    commit();
    applyStimulus(1, 0, 32'h77, 8, 7, 0, 0, 0);
    total++; if (stall_req !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall_off got=%b want=0", stall_req); end
    total++; if (forwardA !== 2'b10) begin bad++; $display("[TB] FAIL lu_forwardA got=%b want=10", forwardA); end
    total++; if (prePreData !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lu_prePreData got=%h want=deadbeef", prePreData); end
    commit();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    total++; if (wb_RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble_wb got=%b want=0", wb_RegWrite); end
    commit();
  endtask

  task automatic test_r0_flush();
    applyStimulus(1, 0, 32'h99, 0, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h5, 11, 0, 0, 0, 0);
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL r0_forwardA got=%b want=00", forwardA); end
    total++; if (forwardB !== 2'b00) begin bad++; $display("[TB] FAIL r0_forwardB got=%b want=00", forwardB); end
    commit();
    applyStimulus(1, 0, 32'hAB, 10, 0, 0, 1, 0); commit();
    applyStimulus(0, 0, 32'h0, 13, 10, 10, 0, 0);
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL flush_forwardA got=%b want=00", forwardA); end
    total++; if (forwardB !== 2'b00) begin bad++; $display("[TB] FAIL flush_forwardB got=%b want=00", forwardB); end
    commit();
    applyStimulus(0, 0, 32'h0, 13, 10, 10, 0, 0);
    total++; if (wb_RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL flush_wb_RegWrite got=%b want=0", wb_RegWrite); end
    total++; if (forwardA !== 2'b00) begin bad++; $display("[TB] FAIL flush_forwardA_mw got=%b want=00", forwardA); end
    commit();
  endtask

  task automatic test_random();
    logic wr = 0, ld = 0, fl = 0;
    logic [31:0] alu = 0;
    logic [4:0] dest = 0, rs = 0, rt = 0;
    logic held = 0;
    for (int i = 0; i < 400; i++) begin
      // The upstream stages freeze during a stall, so the same instruction is presented again.
      if (!held) begin
        wr   = ($urandom_range(0, 3) != 0);
        ld   = ($urandom_range(0, 3) == 0);
        alu  = $urandom;
        dest = 5'($urandom_range(0, 7));
        rs   = 5'($urandom_range(0, 7));
        rt   = 5'($urandom_range(0, 7));
        fl   = ($urandom_range(0, 7) == 0);
      end
      applyStimulus(wr, ld, alu, dest, rs, rt, fl, $urandom);
      held = expStall;
      total++; if (forwardA !== expFwdA) begin bad++; $display("[TB] FAIL rnd_forwardA cyc=%0d got=%b want=%b", i, forwardA, expFwdA); end
      total++; if (forwardB !== expFwdB) begin bad++; $display("[TB] FAIL rnd_forwardB cyc=%0d got=%b want=%b", i, forwardB, expFwdB); end
      total++; if (stall_req !== expStall) begin bad++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b want=%b", i, stall_req, expStall); end
      total++; if (wb_RegWrite !== expWbWr) begin bad++; $display("[TB] FAIL rnd_wb_RegWrite cyc=%0d got=%b want=%b", i, wb_RegWrite, expWbWr); end
      if (expPreKnown) begin
        total++; if (preData !== expPre) begin bad++; $display("[TB] FAIL rnd_preData cyc=%0d got=%h want=%h", i, preData, expPre); end
      end
      if (expWbKnown) begin
        total++; if (prePreData !== expPP) begin bad++; $display("[TB] FAIL rnd_prePreData cyc=%0d got=%h want=%h", i, prePreData, expPP); end
        total++; if (wb_data !== expPP) begin bad++; $display("[TB] FAIL rnd_wb_data cyc=%0d got=%h want=%h", i, wb_data, expPP); end
        total++; if (wb_RegDest !== expWbDest) begin bad++; $display("[TB] FAIL rnd_wb_RegDest cyc=%0d got=%0d want=%0d", i, wb_RegDest, expWbDest); end
      end
`ifdef FWD_STATS_EN
      total++; if (fwd_count !== 16'(cntF)) begin bad++; $display("[TB] FAIL rnd_fwd_count cyc=%0d got=%0d want=%0d", i, fwd_count, cntF); end
      total++; if (stall_count !== 16'(cntS)) begin bad++; $display("[TB] FAIL rnd_stall_count cyc=%0d got=%0d want=%0d", i, stall_count, cntS); end
`else
      total++; if (fwd_count !== 16'd0 || stall_count !== 16'd0) begin bad++; $display("[TB] FAIL rnd_counters_tied got=%0d/%0d want=0/0", fwd_count, stall_count); end
`endif
      commit();
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 32'hCAFE, 6, 0, 0, 0, 0); commit();
    applyStimulus(1, 1, 32'h200, 6, 6, 6, 0, 32'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    total++; if (preData !== 32'd0) begin bad++; $display("[TB] FAIL midrst_preData got=%h want=0", preData); end
    total++; if (prePreData !== 32'd0) begin bad++; $display("[TB] FAIL midrst_prePreData got=%h want=0", prePreData); end
    total++; if (forwardA !== 2'b00 || forwardB !== 2'b00) begin bad++; $display("[TB] FAIL midrst_forward got=%b/%b want=00/00", forwardA, forwardB); end
    total++; if (wb_RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL midrst_wb_RegWrite got=%b want=0", wb_RegWrite); end
    total++; if (stall_count !== 16'd0 || fwd_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_counters got=%0d/%0d want=0/0", fwd_count, stall_count); end
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stats();
    int wantF, wantS;
`ifdef FWD_STATS_EN
    wantF = 3; wantS = 1;
`else
    wantF = 0; wantS = 0;
`endif
    applyStimulus(1, 0, 32'h1, 1, 0, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h2, 2, 1, 0, 0, 0); commit();
    applyStimulus(1, 1, 32'h3, 3, 2, 0, 0, 0); commit();
    applyStimulus(1, 0, 32'h4, 4, 3, 0, 0, 32'h44); commit();
    applyStimulus(1, 0, 32'h4, 4, 3, 0, 0, 0); commit();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    total++; if (fwd_count !== 16'(wantF)) begin bad++; $display("[TB] FAIL stats_fwd_count got=%0d want=%0d", fwd_count, wantF); end
    total++; if (stall_count !== 16'(wantS)) begin bad++; $display("[TB] FAIL stats_stall_count got=%0d want=%0d", stall_count, wantS); end
    commit();
  endtask

  initial begin
    test_reset();
    test_forward_ex();
    test_forward_mem();
    test_priority();
    test_load_use();
    test_r0_flush();
    test_random();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
